sobel_cmd_sequencer: RTL and testbench
======================================

# sobel_cmd_sequencer

Sequences one Sobel frame operation per software command. The Nios PIO command bit (`cmd_in`) starts a run, and the sequencer issues a single-cycle start to the Sobel engine. It waits for the engine's done pulse, then returns completion on the PIO status bit (`status_out`) using a four-phase level handshake. It sits between the Nios PIO pair and the Sobel engine control port, and also provides a frame counter and an optional watchdog.

## Interface
Parameters:
- `FRAME_CNT_W`, default 16: width of the completed-frame counter.
- `TIMEOUT_W`, default 24: width of the watchdog counter.
- `TIMEOUT_CYCLES`, default 24'd10_000_000: cycles allowed in START+RUN before fault; must be ≥ 2.

Ports:
- `clk` in 1: single system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_in` in 1: command level from PIO `out_port`, in the `clk` domain.
- `status_out` out 1: completion level to PIO `in_port`.
- `fault` out 1: watchdog fault flag; sticky until the next accepted command.
- `eng_start` out 1: one-cycle start pulse to the Sobel engine.
- `eng_done` in 1: one-cycle completion pulse from the engine.
- `frame_count` out FRAME_CNT_W: count of successfully completed frames.

## Operation
- **Outputs:** all outputs are registered.
- **Reset values:** `status_out`=0, `fault`=0, `eng_start`=0, `frame_count`=0, state=IDLE, `armed`=0.
- **armed flag:** set on any IDLE cycle with `cmd_in`=0. Prevents a command that is stuck high through reset from triggering a run.
- **States:** IDLE, START, RUN, DONE, FAULT.
- **IDLE:**
  - `armed`=1 and `cmd_in`=1 → START. `eng_start`←1, `fault`←0, `armed`←0, watchdog←0.
- **START:** lasts exactly one cycle; `eng_start`←0.
  - `eng_done`=1 → DONE.
  - Otherwise → RUN.
- **RUN:**
  - `eng_done`=1 → DONE. `status_out`←1, `frame_count`←`frame_count`+1, wrapping modulo 2^FRAME_CNT_W.
  - Watchdog reaches TIMEOUT_CYCLES−1 without done → FAULT. `status_out`←1, `fault`←1.
  - `cmd_in` falling during START/RUN is ignored; the run always completes or times out.
- **DONE / FAULT:**
  - Hold `status_out`=1 until `cmd_in`=0, then → IDLE and `status_out`←0.
  - `armed` is set on the first IDLE cycle with `cmd_in`=0.
  - `eng_done` pulses received in DONE, FAULT or IDLE are ignored and not counted. A late done after a fault does not increment the counter.
- **Done and timeout on the same edge:** done wins (DONE, counter increments, no fault).
- **Watchdog:** counts every cycle in START and RUN. It saturates and never wraps.
- **Software view:** write `cmd`=1, poll status=1, read fault, write `cmd`=0, poll status=0.

## Timing
- `cmd_in` sampled high at edge k (IDLE, armed): `eng_start`=1 for the cycle between edges k+1 and k+2. Latency from command to start is 1 clock.
- `eng_done` sampled at edge m: `status_out` and `frame_count` are updated after edge m+1.
- `cmd_in` sampled low at edge d in DONE/FAULT: `status_out`=0 after edge d+1. The earliest next start pulse follows edge d+3.
- Timeout: `fault` asserts TIMEOUT_CYCLES+1 edges after the edge that sampled the command.
- `reset` asserted mid-run: all outputs return to reset values on the next edge. The engine is not notified, and its later done is ignored in IDLE.

## Configuration
- Macro: `SOBEL_CMD_TIMEOUT_EN`.
- **Defined:** the watchdog counter and the FAULT state are built.
- **Undefined:**
  - No watchdog counter or FAULT state; RUN waits indefinitely for `eng_done`.
  - `fault` is tied to 0.
  - `TIMEOUT_W` and `TIMEOUT_CYCLES` are unused.

## Structure
- Shared package `sobel_ctrl_pkg` holds the `seq_state_t` enum (IDLE, START, RUN, DONE, FAULT) and the default-width localparams.
- One sub-module: `sobel_watchdog`. It is a saturating counter with clear, enable and expire outputs, and is instantiated only under the macro.
- The FSM and the frame counter stay in the top module.

## Test plan
- **Normal run:** reset, hold `cmd_in`=0 for 2 cycles, then raise it. Expect `eng_start` as a single 1-cycle pulse one clock later. `eng_done` 20 cycles later → `status_out`=1 and `frame_count`=1. Drop `cmd_in` → `status_out`=0 after one clock.
- **Stuck command:** `cmd_in`=1 throughout and after reset → no `eng_start`. Drop and re-raise `cmd_in` → exactly one start.
- **Timeout:** with the macro and TIMEOUT_CYCLES=8, never pulse done → `fault`=1 and `status_out`=1 after 9 edges, `frame_count` unchanged. A late `eng_done` is ignored. The next command clears `fault`.
- **Same-edge done and timeout:** `eng_done` on the timeout edge → DONE, `fault`=0, count incremented.
- **Counter wrap:** with FRAME_CNT_W=2, run 5 frames → `frame_count`=1.
- **Reset mid-RUN:** assert `reset` during RUN → all outputs 0 and state IDLE. A subsequent `eng_done` leaves `frame_count`=0.

Source files
------------

// File: rtl/sobel_ctrl_pkg.sv
// Shared types and default widths for the Sobel command sequencer.
package sobel_ctrl_pkg;

  localparam int unsigned LP_FRAME_CNT_W    = 16;
  localparam int unsigned LP_TIMEOUT_W      = 24;
  localparam int unsigned LP_TIMEOUT_CYCLES = 10_000_000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    DONE,
    FAULT
  } seq_state_t;

endpackage

// File: rtl/sobel_watchdog.sv
// Saturating run-time watchdog for the Sobel sequencer.
// Exists only when SOBEL_CMD_TIMEOUT_EN is defined.
`ifdef SOBEL_CMD_TIMEOUT_EN
module sobel_watchdog #(
  parameter int unsigned TIMEOUT_W      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TIMEOUT_W-1:0] LP_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] r_count;

  // Holds at the terminal value so a stalled run can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LP_LAST)) begin
      r_count <= r_count + TIMEOUT_W'(1);
    end
  end

  assign o_expire = (r_count == LP_LAST);

endmodule
`endif

// File: rtl/sobel_cmd_sequencer.sv
// PIO command to Sobel engine sequencer with four-phase status handshake.
// Optional watchdog/FAULT path built when SOBEL_CMD_TIMEOUT_EN is defined.
module sobel_cmd_sequencer
  import sobel_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_CNT_W    = LP_FRAME_CNT_W,
  parameter int unsigned TIMEOUT_W      = LP_TIMEOUT_W,
  parameter int unsigned TIMEOUT_CYCLES = LP_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_in,
  output logic                   status_out,
  output logic                   fault,
  output logic                   eng_start,
  input  logic                   eng_done,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  // state | meaning
  // IDLE  | waiting for an armed command
  // START | engine start pulse is on the wire
  // RUN   | waiting for engine done (or watchdog)
  // DONE  | frame finished, status high until cmd drops
  // FAULT | watchdog expired, status high until cmd drops

  if (TIMEOUT_CYCLES < 2 || ((64'(TIMEOUT_CYCLES) - 64'd1) >> TIMEOUT_W) != 64'd0) begin : g_bad_timeout_cfg
    $error("sobel_cmd_sequencer: TIMEOUT_CYCLES must be >= 2 and fit in TIMEOUT_W bits");
  end

  seq_state_t             r_state, w_state_nxt;
  logic                   r_cmd, r_done;
  logic                   r_armed, w_armed_nxt;
  logic                   r_status, w_status_nxt;
  logic                   r_eng_start, w_eng_start_nxt;
  logic [FRAME_CNT_W-1:0] r_frame_count, w_frame_count_nxt;

`ifdef SOBEL_CMD_TIMEOUT_EN
  logic r_fault, w_fault_nxt;
  logic w_wd_clr, w_wd_en, w_wd_expire;

  sobel_watchdog #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_wd_expire)
  );

  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

  // r_cmd resets high so a command held through reset is never seen as a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd         <= 1'b1;
      r_done        <= 1'b0;
      r_state       <= IDLE;
      r_armed       <= 1'b0;
      r_status      <= 1'b0;
      r_eng_start   <= 1'b0;
      r_frame_count <= '0;
`ifdef SOBEL_CMD_TIMEOUT_EN
      r_fault       <= 1'b0;
`endif
    end else begin
      r_cmd         <= cmd_in;
      r_done        <= eng_done;
      r_state       <= w_state_nxt;
      r_armed       <= w_armed_nxt;
      r_status      <= w_status_nxt;
      r_eng_start   <= w_eng_start_nxt;
      r_frame_count <= w_frame_count_nxt;
`ifdef SOBEL_CMD_TIMEOUT_EN
      r_fault       <= w_fault_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_armed_nxt       = r_armed;
    w_status_nxt      = r_status;
    w_eng_start_nxt   = 1'b0;
    w_frame_count_nxt = r_frame_count;
`ifdef SOBEL_CMD_TIMEOUT_EN
    w_fault_nxt       = r_fault;
    w_wd_clr          = 1'b0;
    w_wd_en           = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (r_armed && r_cmd) begin
          w_state_nxt     = START;
          w_eng_start_nxt = 1'b1;
          w_armed_nxt     = 1'b0;
`ifdef SOBEL_CMD_TIMEOUT_EN
          w_fault_nxt     = 1'b0;
          w_wd_clr        = 1'b1;
`endif
        end else if (!r_cmd) begin
          w_armed_nxt = 1'b1;
        end
      end
      START, RUN: begin
`ifdef SOBEL_CMD_TIMEOUT_EN
        w_wd_en = 1'b1;
`endif
        // Done takes priority over an expiry on the same edge.
        if (r_done) begin
          w_state_nxt       = DONE;
          w_status_nxt      = 1'b1;
          w_frame_count_nxt = r_frame_count + FRAME_CNT_W'(1);
        end else if (r_state == START) begin
          w_state_nxt = RUN;
`ifdef SOBEL_CMD_TIMEOUT_EN
        end else if (w_wd_expire) begin
          w_state_nxt  = FAULT;
          w_status_nxt = 1'b1;
          w_fault_nxt  = 1'b1;
`endif
        end
      end
`ifdef SOBEL_CMD_TIMEOUT_EN
      DONE, FAULT: begin
`else
      DONE: begin
`endif
        if (!r_cmd) begin
          w_state_nxt  = IDLE;
          w_status_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_status_nxt = 1'b0;
      end
    endcase
  end

  assign status_out  = r_status;
  assign eng_start   = r_eng_start;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_sobel_cmd_sequencer.sv
// Directed self-checking bench for sobel_cmd_sequencer (FRAME_CNT_W=2, TIMEOUT_CYCLES=8).
module tb_sobel_cmd_sequencer;

  localparam int FCW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cmd_in = 1'b0;
  logic           eng_done = 1'b0;
  logic           status_out, fault, eng_start;
  logic [FCW-1:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sobel_cmd_sequencer #(
    .FRAME_CNT_W    (FCW),
    .TIMEOUT_W      (24),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_in      (cmd_in),
    .status_out  (status_out),
    .fault       (fault),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .frame_count (frame_count)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input logic cmd_lvl);
    reset = 1'b1; cmd_in = cmd_lvl; eng_done = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  // Leaves the sequencer in DONE with cmd_in held high.
  task automatic do_run(input int wait_cycles);
    cmd_in = 1'b0; step(3);
    cmd_in = 1'b1; step(2 + wait_cycles);
    eng_done = 1'b1; step(1);
    eng_done = 1'b0; step(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_in = 1'b0; eng_done = 1'b0;
    step(2);
    n_cmp++; if (status_out !== 1'b0) begin n_bad++; $display("FAIL reset_status: got %b want 0", status_out); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", eng_start); end
    n_cmp++; if (frame_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", frame_count); end
    reset = 1'b0;
  endtask

  task automatic test_normal();
    apply_reset(1'b0);
    step(2);
    cmd_in = 1'b1; step(1);
    n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL start_early: got %b want 0", eng_start); end
    step(1);
    n_cmp++; if (eng_start !== 1'b1) begin n_bad++; $display("FAIL start_pulse: got %b want 1", eng_start); end
    step(1);
    n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL start_single: got %b want 0", eng_start); end
    for (int i = 0; i < 18; i++) begin
      step(1);
      n_cmp++; if (eng_start !== 1'b0 || status_out !== 1'b0) begin
        n_bad++; $display("FAIL run_quiet: cycle %0d start=%b status=%b want 0/0", i, eng_start, status_out);
      end
    end
    eng_done = 1'b1; step(1);
    eng_done = 1'b0;
    n_cmp++; if (status_out !== 1'b0) begin n_bad++; $display("FAIL status_latency: got %b want 0", status_out); end
    step(1);
    n_cmp++; if (status_out !== 1'b1) begin n_bad++; $display("FAIL status_set: got %b want 1", status_out); end
    n_cmp++; if (frame_count !== 2'd1) begin n_bad++; $display("FAIL count_first: got %0d want 1", frame_count); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL normal_fault: got %b want 0", fault); end
    step(3);
    n_cmp++; if (status_out !== 1'b1) begin n_bad++; $display("FAIL status_held: got %b want 1", status_out); end
    cmd_in = 1'b0; step(1);
    n_cmp++; if (status_out !== 1'b1) begin n_bad++; $display("FAIL status_drop_lat: got %b want 1", status_out); end
    step(1);
    n_cmp++; if (status_out !== 1'b0) begin n_bad++; $display("FAIL status_clear: got %b want 0", status_out); end
  endtask

  task automatic test_stuck_cmd();
    int pulses;
    apply_reset(1'b1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (eng_start === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL stuck_no_start: got %0d pulses want 0", pulses); end
    cmd_in = 1'b0; step(2);
    cmd_in = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (eng_start === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL rearm_one_start: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_counter_wrap();
    logic [FCW-1:0] exp_cnt;
    apply_reset(1'b0);
    for (int r = 0; r < 5; r++) begin
      do_run(3 + r);
      exp_cnt = FCW'((r + 1) % 4);
      n_cmp++; if (frame_count !== exp_cnt) begin n_bad++; $display("FAIL wrap_count: run %0d got %0d want %0d", r, frame_count, exp_cnt); end
      n_cmp++; if (status_out !== 1'b1) begin n_bad++; $display("FAIL wrap_status: run %0d got %b want 1", r, status_out); end
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset(1'b0);
    do_run(2);
    cmd_in = 1'b0; step(3);
    cmd_in = 1'b1; step(4);
    reset = 1'b1; step(1);
    n_cmp++; if (frame_count !== 2'd0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", frame_count); end
    n_cmp++; if (status_out !== 1'b0 || eng_start !== 1'b0 || fault !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outputs: status=%b start=%b fault=%b want 0/0/0", status_out, eng_start, fault);
    end
    reset = 1'b0;
    eng_done = 1'b1; step(1);
    eng_done = 1'b0; step(4);
    n_cmp++; if (frame_count !== 2'd0) begin n_bad++; $display("FAIL midrst_late_done: got %0d want 0", frame_count); end
    n_cmp++; if (status_out !== 1'b0) begin n_bad++; $display("FAIL midrst_status: got %b want 0", status_out); end
  endtask

`ifdef SOBEL_CMD_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset(1'b0);
    step(2);
    cmd_in = 1'b1; step(1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL tmo_early: edge %0d got %b want 0", i, fault); end
    end
    step(1);
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL tmo_fault: got %b want 1", fault); end
    n_cmp++; if (status_out !== 1'b1) begin n_bad++; $display("FAIL tmo_status: got %b want 1", status_out); end
    n_cmp++; if (frame_count !== 2'd0) begin n_bad++; $display("FAIL tmo_count: got %0d want 0", frame_count); end
    eng_done = 1'b1; step(1);
    eng_done = 1'b0; step(2);
    n_cmp++; if (frame_count !== 2'd0) begin n_bad++; $display("FAIL tmo_late_done: got %0d want 0", frame_count); end
    cmd_in = 1'b0; step(3);
    n_cmp++; if (status_out !== 1'b0) begin n_bad++; $display("FAIL tmo_status_clr: got %b want 0", status_out); end
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", fault); end
    cmd_in = 1'b1; step(2);
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL tmo_fault_clr: got %b want 0", fault); end
    n_cmp++; if (eng_start !== 1'b1) begin n_bad++; $display("FAIL tmo_restart: got %b want 1", eng_start); end
  endtask

  task automatic test_same_edge();
    apply_reset(1'b0);
    step(2);
    cmd_in = 1'b1; step(1);
    step(7);
    eng_done = 1'b1; step(1);
    eng_done = 1'b0; step(1);
    n_cmp++; if (status_out !== 1'b1) begin n_bad++; $display("FAIL same_status: got %b want 1", status_out); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL same_fault: got %b want 0", fault); end
    n_cmp++; if (frame_count !== 2'd1) begin n_bad++; $display("FAIL same_count: got %0d want 1", frame_count); end
    step(2);
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL same_fault_hold: got %b want 0", fault); end
  endtask
`else
  task automatic test_no_watchdog();
    apply_reset(1'b0);
    step(2);
    cmd_in = 1'b1; step(40);
    n_cmp++; if (status_out !== 1'b0) begin n_bad++; $display("FAIL nowd_status: got %b want 0", status_out); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL nowd_fault: got %b want 0", fault); end
    eng_done = 1'b1; step(1);
    eng_done = 1'b0; step(1);
    n_cmp++; if (status_out !== 1'b1) begin n_bad++; $display("FAIL nowd_done: got %b want 1", status_out); end
    n_cmp++; if (frame_count !== 2'd1) begin n_bad++; $display("FAIL nowd_count: got %0d want 1", frame_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_stuck_cmd();
    test_counter_wrap();
    test_reset_mid_run();
`ifdef SOBEL_CMD_TIMEOUT_EN
    test_timeout();
    test_same_edge();
`else
    test_no_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
